// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared state encoding and constants for the fetch stage
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    WAIT    = 2'b01,
    DISCARD = 2'b10
  } ifu_state_e;

  localparam logic [31:0] IFU_RESET_PC = 32'h3000_0000;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;

endpackage

// File: rtl/ifu_out_reg.sv
// rtl/ifu_out_reg.sv - one-entry valid/ready register slice holding {inst, pc} with flush
module ifu_out_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_inst_i,
  input  logic [WIDTH-1:0] load_pc_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] inst_o,
  output logic [WIDTH-1:0] pc_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] inst_q, inst_d;
  logic [WIDTH-1:0] pc_q, pc_d;

  // Flush beats a new load, a new load beats a drain; the caller only loads when the slot is free or draining.
  always_comb begin
    valid_d = valid_q;
    inst_d  = inst_q;
    pc_d    = pc_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      inst_d  = load_inst_i;
      pc_d    = load_pc_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Slot registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      inst_q  <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      inst_q  <= inst_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o = valid_q;
  assign inst_o  = inst_q;
  assign pc_o    = pc_q;

endmodule

// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - fetch PC owner, single-outstanding icache requester and decode handoff
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(IFU_RESET_PC)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             icache_rready_i,
  input  logic             icache_rvalid_i,
  input  logic [WIDTH-1:0] icache_rdata_i,
  output logic             ifu_rreq_o,
  output logic [WIDTH-1:0] ifu_raddr_o,
  input  logic             redirect_valid_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  output logic             inst_valid_o,
  input  logic             inst_ready_i,
  output logic [WIDTH-1:0] inst_o,
  output logic [WIDTH-1:0] pc_o
);

  localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

  ifu_state_e       state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] req_addr_q, req_addr_d;

  logic             out_valid;
  logic             can_issue;
  logic             rreq;
  logic [WIDTH-1:0] raddr;
  logic             load;
  logic [WIDTH-1:0] load_pc;
  logic [WIDTH-1:0] redirect_target;

  assign redirect_target = redirect_pc_i & ALIGN_MASK;
  assign can_issue       = icache_rready_i && (!out_valid || inst_ready_i) && !redirect_valid_i;

  // Request/capture control; a redirect always wins the pc update and squashes the output slot.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    rreq       = 1'b0;
    raddr      = pc_q;
    load       = 1'b0;
    load_pc    = pc_q;
    case (state_q)
      IDLE: begin
        rreq  = can_issue;
        raddr = pc_q;
        if (can_issue) begin
          req_addr_d = pc_q;
          if (icache_rvalid_i) begin
            load    = 1'b1;
            load_pc = pc_q;
            pc_d    = pc_q + PC_STEP;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        rreq  = 1'b1;
        raddr = req_addr_q;
        if (redirect_valid_i) begin
          state_d = icache_rvalid_i ? IDLE : DISCARD;
        end else if (icache_rvalid_i) begin
          load    = 1'b1;
          load_pc = req_addr_q;
          pc_d    = req_addr_q + PC_STEP;
          state_d = IDLE;
        end
      end
      DISCARD: begin
        // The refill cannot be aborted, so the stale request stays up until it drains.
        rreq  = 1'b1;
        raddr = req_addr_q;
        if (icache_rvalid_i) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (redirect_valid_i) begin
      pc_d = redirect_target;
    end
  end

  // State, fetch pc and outstanding request address.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_addr_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
    end
  end

  assign ifu_rreq_o  = rreq && !reset;
  assign ifu_raddr_o = raddr;

  ifu_out_reg #(
    .WIDTH(WIDTH)
  ) u_out_reg (
    .clock       (clock),
    .reset       (reset),
    .flush_i     (redirect_valid_i),
    .load_i      (load),
    .load_inst_i (icache_rdata_i),
    .load_pc_i   (load_pc),
    .ready_i     (inst_ready_i),
    .valid_o     (out_valid),
    .inst_o      (inst_o),
    .pc_o        (pc_o)
  );

  assign inst_valid_o = out_valid;

endmodule
